lbc_burst_splitter: RTL and testbench

Converts a 68040 line (burst) transfer into four sequential single-longword cycles for the bus-sizing stage, which cannot burst toward Amiga-side targets. Sits directly upstream of the bus-sizing cycle state machine on CLK40. It holds the CPU cycle open, returns one TA per completed beat so the CPU sees a normal four-beat burst, and passes non-line transfers through as single cycles. A watchdog terminates any downstream beat that never acknowledges.

---
 rtl/lbc_burst_splitter.sv | 82 ++++++++
 tb/tb_lbc_burst_splitter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lbc_burst_splitter.sv
// lbc_burst_splitter: breaks a 68040 line transfer into four single-longword downstream cycles,
// acknowledging each beat back to the CPU, with a watchdog that forces TEA on a stalled beat.
module lbc_burst_splitter #(
  parameter int TIMEOUT = 255
) (
  input  logic       CLK40,
  input  logic       RESET,
  input  logic       TS_CPUn,
  input  logic [1:0] SIZ,
  input  logic [1:0] A_040,
  input  logic       RnW,
  input  logic       TA_DNn,
  input  logic       TEA_DNn,
  output logic       TS_DNn,
  output logic [1:0] SIZ_DN,
  output logic [1:0] A_DN,
  output logic       RnW_DN,
  output logic       TA_CPUn,
  output logic       TEA_CPUn,
  output logic       BUSY
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t     state;
  logic [1:0] beats;
  logic [7:0] wd;
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state    <= IDLE;
      beats    <= 2'd0;
      wd       <= 8'd0;
      TS_DNn   <= 1'b1;
      TA_CPUn  <= 1'b1;
      TEA_CPUn <= 1'b1;
      SIZ_DN   <= 2'b00;
      A_DN     <= 2'b00;
      RnW_DN   <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      TS_DNn   <= 1'b1;
      TA_CPUn  <= 1'b1;
      TEA_CPUn <= 1'b1;
      case (state)
        IDLE: if (!TS_CPUn) begin
          // downstream fields are loaded on entry so they are valid throughout ISSUE
          state  <= ISSUE;
          beats  <= &SIZ ? 2'd3 : 2'd0;
          SIZ_DN <= &SIZ ? 2'b00 : SIZ;
          A_DN   <= A_040;
          RnW_DN <= RnW;
          TS_DNn <= 1'b0;
          BUSY   <= 1'b1;
        end
        ISSUE: begin
          wd    <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + 8'd1;
          // an error, or a watchdog expiry with no TA, ends the whole transfer
          if (!TEA_DNn || (!(!TA_DNn) && wd == 8'(TIMEOUT - 1))) begin
            TEA_CPUn <= 1'b0;
            beats    <= 2'd0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end else if (!TA_DNn) begin
            TA_CPUn <= 1'b0;
            if (beats == 2'd0) begin
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              beats  <= beats - 2'd1;
              A_DN   <= A_DN + 2'd1;
              TS_DNn <= 1'b0;
              state  <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbc_burst_splitter.sv
// tb_lbc_burst_splitter: directed and random transfers checked against a beat-level model of the splitter.
module tb_lbc_burst_splitter;
  localparam int TO = 4;
  logic       CLK40 = 1'b0;
  logic       RESET, TS_CPUn, RnW, TA_DNn, TEA_DNn;
  logic [1:0] SIZ, A_040;
  logic       TS_DNn, RnW_DN, TA_CPUn, TEA_CPUn, BUSY;
  logic [1:0] SIZ_DN, A_DN;
  int errors = 0;
  int checks = 0;
  // per-beat plan: knd 0=TA, 1=TEA, 2=TA+TEA together, 3=no response; dly=WAIT cycles before the response
  int dly[4];
  int knd[4];

  lbc_burst_splitter #(.TIMEOUT(TO)) dut (
    .CLK40(CLK40), .RESET(RESET), .TS_CPUn(TS_CPUn), .SIZ(SIZ), .A_040(A_040), .RnW(RnW),
    .TA_DNn(TA_DNn), .TEA_DNn(TEA_DNn), .TS_DNn(TS_DNn), .SIZ_DN(SIZ_DN), .A_DN(A_DN),
    .RnW_DN(RnW_DN), .TA_CPUn(TA_CPUn), .TEA_CPUn(TEA_CPUn), .BUSY(BUSY)
  );

  always #5 CLK40 = ~CLK40;

  task automatic tick;
    @(posedge CLK40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ts_dn"}, 8'(TS_DNn), 8'd1);
    chk({tag, "_ta"}, 8'(TA_CPUn), 8'd1);
    chk({tag, "_tea"}, 8'(TEA_CPUn), 8'd1);
    chk({tag, "_siz_dn"}, 8'(SIZ_DN), 8'd0);
    chk({tag, "_a_dn"}, 8'(A_DN), 8'd0);
    chk({tag, "_rnw_dn"}, 8'(RnW_DN), 8'd1);
    chk({tag, "_busy"}, 8'(BUSY), 8'd0);
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_ts_dn"}, 8'(TS_DNn), 8'd1);
    chk({tag, "_ta"}, 8'(TA_CPUn), 8'd1);
    chk({tag, "_tea"}, 8'(TEA_CPUn), 8'd1);
    chk({tag, "_busy"}, 8'(BUSY), 8'd0);
  endtask

  // one CPU transfer; rb selects a beat whose first WAIT cycle is hit by RESET (-1 for none)
  task automatic run_xfer(input logic [1:0] siz, input logic [1:0] a, input logic rnw, input int rb);
    int nb;
    int waits;
    bit done;
    logic [1:0] ea;
    nb = (siz == 2'b11) ? 4 : 1;
    done = 0;
    TS_CPUn = 1'b0; SIZ = siz; A_040 = a; RnW = rnw;
    tick;
    TS_CPUn = 1'b1; SIZ = 2'($urandom); A_040 = 2'($urandom); RnW = 1'($urandom);
    for (int b = 0; b < nb && !done; b++) begin
      ea = a + 2'(b);
      chk("issue_ts_dn", 8'(TS_DNn), 8'd0);
      chk("issue_a_dn", 8'(A_DN), 8'(ea));
      chk("issue_siz_dn", 8'(SIZ_DN), (siz == 2'b11) ? 8'd0 : 8'(siz));
      chk("issue_rnw_dn", 8'(RnW_DN), 8'(rnw));
      chk("issue_busy", 8'(BUSY), 8'd1);
      chk("issue_ta", 8'(TA_CPUn), (b > 0) ? 8'd0 : 8'd1);
      TA_DNn = 1'($urandom_range(1)); TEA_DNn = 1'($urandom_range(1)); TS_CPUn = 1'($urandom_range(1));
      tick;
      TA_DNn = 1'b1; TEA_DNn = 1'b1; TS_CPUn = 1'b1;
      if (b == rb) begin
        RESET = 1'b1; TA_DNn = 1'b0;
        tick;
        RESET = 1'b0; TA_DNn = 1'b1;
        chk_reset("rst_mid");
        repeat (3) begin
          TA_DNn = 1'($urandom_range(1));
          tick;
          quiet("after_rst");
        end
        TA_DNn = 1'b1;
        return;
      end
      waits = (knd[b] == 3) ? TO : dly[b] + 1;
      for (int w = 0; w < waits; w++) begin
        chk("wait_ts_dn", 8'(TS_DNn), 8'd1);
        chk("wait_ta", 8'(TA_CPUn), 8'd1);
        chk("wait_tea", 8'(TEA_CPUn), 8'd1);
        chk("wait_busy", 8'(BUSY), 8'd1);
        if (w == waits - 1 && knd[b] != 3) begin
          TA_DNn = 1'(knd[b] == 1);
          TEA_DNn = 1'(knd[b] == 0);
        end
        TS_CPUn = 1'($urandom_range(1));
        tick;
        TA_DNn = 1'b1; TEA_DNn = 1'b1; TS_CPUn = 1'b1;
      end
      if (knd[b] == 0) begin
        chk("beat_ta", 8'(TA_CPUn), 8'd0);
        chk("beat_tea", 8'(TEA_CPUn), 8'd1);
        if (b == nb - 1) begin
          chk("last_busy", 8'(BUSY), 8'd0);
          chk("last_ts_dn", 8'(TS_DNn), 8'd1);
        end
      end else begin
        chk("err_tea", 8'(TEA_CPUn), 8'd0);
        chk("err_ta", 8'(TA_CPUn), 8'd1);
        chk("err_busy", 8'(BUSY), 8'd0);
        chk("err_ts_dn", 8'(TS_DNn), 8'd1);
        done = 1;
      end
    end
    tick;
    quiet("idle_after");
  endtask

  task automatic plan(input int k0, input int k1, input int k2, input int k3, input int d);
    knd[0] = k0; knd[1] = k1; knd[2] = k2; knd[3] = k3;
    for (int i = 0; i < 4; i++) dly[i] = d;
  endtask

  initial begin
    RESET = 1'b1; TS_CPUn = 1'b1; SIZ = 2'b00; A_040 = 2'b00; RnW = 1'b1; TA_DNn = 1'b1; TEA_DNn = 1'b1;
    tick;
    tick;
    chk_reset("reset");
    RESET = 1'b0;
    tick;
    quiet("post_reset");
    plan(0, 0, 0, 0, 1);
    run_xfer(2'b00, 2'b01, 1'b1, -1);
    plan(0, 0, 0, 0, 0);
    run_xfer(2'b11, 2'b10, 1'b0, -1);
    plan(0, 1, 0, 0, 0);
    run_xfer(2'b11, 2'b01, 1'b1, -1);
    plan(2, 0, 0, 0, 0);
    run_xfer(2'b11, 2'b00, 1'b0, -1);
    plan(3, 0, 0, 0, 0);
    run_xfer(2'b10, 2'b11, 1'b1, -1);
    plan(0, 0, 0, 0, TO - 1);
    run_xfer(2'b01, 2'b10, 1'b0, -1);
    TA_DNn = 1'b0; TEA_DNn = 1'b0;
    tick;
    TA_DNn = 1'b1; TEA_DNn = 1'b1;
    tick;
    quiet("idle_noise");
    plan(0, 0, 0, 0, 0);
    run_xfer(2'b11, 2'b11, 1'b1, 2);
    plan(0, 0, 0, 0, 0);
    run_xfer(2'b11, 2'b01, 1'b0, -1);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(11);
        knd[i] = (r < 9) ? 0 : r - 8;
        dly[i] = $urandom_range(TO - 1);
      end
      run_xfer(2'($urandom), 2'($urandom), 1'($urandom), -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
